sync_fifo_wr_arbiter: RTL and testbench
=======================================

Name: sync_fifo_wr_arbiter

Overview:
- Shares one sync FIFO write port among N_REQ producers.
- Round-robin arbitration with optional burst lock: a winner keeps the port for up to MAX_BURST consecutive writes.
- Drives the FIFO's write_i/wr_data_i and observes full_o. Producers see a per-requester accept strobe.
- Sits between producer blocks and sync_fifo_interface; the read side is untouched.

Parameters:
- DATA_WIDTH, 32, write data bits; matches the FIFO interface.
- N_REQ, 4, number of requesters, 2..16.
- MAX_BURST, 4, max consecutive writes per grant, 1..256. A value of 1 gives pure round-robin per word.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- req_i  in  N_REQ  per-requester write request; held until accepted.
- data_i  in  N_REQ*DATA_WIDTH  packed write data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- gnt_o  out  N_REQ  one-hot accept strobe; the word is taken this cycle.
- fifo_write_o  out  1  to FIFO write_i.
- fifo_wr_data_o  out  DATA_WIDTH  to FIFO wr_data_i.
- fifo_full_i  in  1  from FIFO full_o.
- owner_o  out  clog2(N_REQ)  registered current/last owner id.
- burst_o  out  1  registered; high while in BURST.

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - state=IDLE, rr_ptr=N_REQ-1 (requester 0 has top priority first), burst_cnt=0, owner_o=0, burst_o=0.
  - gnt_o and fifo_write_o are forced 0 in any cycle where rst_n_i=0.
  - A reset mid-burst abandons the burst; no write occurs in the reset cycle.
- Write path is combinational, zero latency:
  - fifo_write_o = |gnt_o.
  - fifo_wr_data_o = data of the granted requester, else 0.
  - At most one gnt_o bit is set.
  - A grant is never issued while fifo_full_i=1, so the FIFO never sees overflow.
- Handshake: the producer holds req_i and data stable until it sees gnt_o[k]=1 at a clock edge. Deasserting req without a grant is allowed (request withdrawn).
- FSM IDLE:
  - If any req_i and !fifo_full_i, the winner is the first set req scanning from (rr_ptr+1) mod N_REQ upward with wrap. gnt_o[winner]=1 and owner_o<=winner.
  - If MAX_BURST>1: go to BURST with burst_cnt<=1.
  - Else stay in IDLE with rr_ptr<=winner.
  - If full or no req: no grant, state holds.
- FSM BURST (owner fixed):
  - req_i[owner] && !fifo_full_i: grant owner, burst_cnt++. If the new count equals MAX_BURST, go to IDLE with rr_ptr<=owner and burst_cnt<=0.
  - req_i[owner] && fifo_full_i: no grant; count and state hold. Other requesters stay blocked.
  - !req_i[owner]: no grant this cycle (one bubble); go to IDLE, rr_ptr<=owner.
- burst_cnt is clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST.
- Full deasserting and req arriving in the same cycle: the grant is issued that cycle.

Optional Feature:
- Macro SYNC_FIFO_ARB_STATS_EN.
- When defined, adds output ports:
  - stall_cnt_o (32 bits): increments each cycle with any req_i set and fifo_full_i=1.
  - wr_cnt_o (32 bits): increments each cycle fifo_write_o=1.
  - Both saturate at all-ones and clear on reset.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then req_i=4'b1111 held, FIFO never full, MAX_BURST=1: grants 0,1,2,3,0,... one per cycle; fifo_wr_data_o matches each granted slot.
- MAX_BURST=4, req_i=4'b0101 held: requester 0 gets 4 consecutive grants (burst_o=1), then requester 2 gets 4; owner_o toggles 0→2→0.
- Mid-burst (burst_cnt=2, owner 1), fifo_full_i=1 for 3 cycles while req_i=4'b0011: no grants during those cycles; after full drops, owner 1 gets exactly 2 more grants, then requester 0 is granted.
- Owner 3 drops req after 1 write in a burst, req_i[0] held: one bubble cycle with no grant, then gnt_o=4'b0001.
- rst_n_i pulled low for 1 cycle during a burst of owner 2: no write that cycle; after reset, req_i=4'b0110 grants requester 1 first (rr_ptr=N_REQ-1).
- SYNC_FIFO_ARB_STATS_EN defined: 10 writes plus 5 full-stalled request cycles give wr_cnt_o=10, stall_cnt_o=5.

Source files
------------

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write-port arbiter with burst lock in front of a sync FIFO.
// Optional stall/write counters are enabled with `define SYNC_FIFO_ARB_STATS_EN.
module sync_fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   data_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic                          fifo_write_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  input  logic                          fifo_full_i,
  output logic [$clog2(N_REQ)-1:0]      owner_o,
`ifdef SYNC_FIFO_ARB_STATS_EN
  output logic [31:0]                   stall_cnt_o,
  output logic [31:0]                   wr_cnt_o,
`endif
  output logic                          burst_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;

  logic               w_found;
  logic [IDX_W-1:0]   w_winner;

  // Scan from the slot after the last owner, wrapping, so every requester gets a turn.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    // NOTE: every comb output gets a default up front, otherwise a missed branch infers a latch.
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      v_idx = IDX_W'((int'(r_rr_ptr) + i) % N_REQ);
      if (!w_found && req_i[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_rr_ptr    <= IDX_W'(N_REQ - 1);
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (w_found && !fifo_full_i) begin
          w_owner_nxt = w_winner;
          if (MAX_BURST > 1) begin
            w_state_nxt     = BURST;
            w_burst_cnt_nxt = CNT_W'(1);
          end else begin
            w_rr_ptr_nxt = w_winner;
          end
        end
      end
      BURST: begin
        if (req_i[r_owner]) begin
          if (!fifo_full_i) begin
            if (r_burst_cnt == CNT_W'(MAX_BURST - 1)) begin
              w_state_nxt     = IDLE;
              w_rr_ptr_nxt    = r_owner;
              w_burst_cnt_nxt = '0;
            end else begin
              w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
            end
          end
        end else begin
          // Owner withdrew: spend one bubble cycle and hand back to round-robin.
          w_state_nxt     = IDLE;
          w_rr_ptr_nxt    = r_owner;
          w_burst_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: grants are combinational and suppressed while full or in reset.
  always_comb begin
    gnt_o = '0;
    if (rst_n_i && !fifo_full_i) begin
      case (r_state)
        IDLE:    if (w_found)         gnt_o[w_winner] = 1'b1;
        BURST:   if (req_i[r_owner])  gnt_o[r_owner]  = 1'b1;
        default: gnt_o = '0;
      endcase
    end
  end

  always_comb begin
    fifo_wr_data_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_o[k]) fifo_wr_data_o = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_write_o = |gnt_o;
  assign owner_o      = r_owner;
  assign burst_o      = (r_state == BURST);

`ifdef SYNC_FIFO_ARB_STATS_EN
  logic [31:0] r_stall_cnt, r_wr_cnt;

  // Saturating event counters
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
      r_wr_cnt    <= '0;
    end else begin
      if (|req_i && fifo_full_i && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (fifo_write_o && r_wr_cnt != '1)              r_wr_cnt    <= r_wr_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign wr_cnt_o    = r_wr_cnt;
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed bench for sync_fifo_wr_arbiter: one instance with MAX_BURST=1, one with MAX_BURST=4.
module tb_sync_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  data;
  logic              full = 1'b0;

  logic [NR-1:0] gnt1, gnt4;
  logic          wr1, wr4;
  logic [DW-1:0] wd1, wd4;
  logic [1:0]    own1, own4;
  logic          bur1, bur4;
`ifdef SYNC_FIFO_ARB_STATS_EN
  logic [31:0]   stall1, wcnt1, stall4, wcnt4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .MAX_BURST(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .data_i(data), .gnt_o(gnt1),
    .fifo_write_o(wr1), .fifo_wr_data_o(wd1), .fifo_full_i(full), .owner_o(own1),
`ifdef SYNC_FIFO_ARB_STATS_EN
    .stall_cnt_o(stall1), .wr_cnt_o(wcnt1),
`endif
    .burst_o(bur1)
  );

  sync_fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .MAX_BURST(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .data_i(data), .gnt_o(gnt4),
    .fifo_write_o(wr4), .fifo_wr_data_o(wd4), .fifo_full_i(full), .owner_o(own4),
`ifdef SYNC_FIFO_ARB_STATS_EN
    .stall_cnt_o(stall4), .wr_cnt_o(wcnt4),
`endif
    .burst_o(bur4)
  );

  function automatic logic [31:0] dval(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h1111;
  endfunction

  function automatic logic [31:0] exp_data(input logic [NR-1:0] g);
    exp_data = '0;
    for (int k = 0; k < NR; k++) if (g[k]) exp_data = dval(k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the combinational write path, then the registered state.
  task automatic step(input bit use4, input string tag, input logic [NR-1:0] q, input logic f,
                      input logic [NR-1:0] eg, input logic eb, input logic [1:0] eo);
    rst_n = 1'b1; req = q; full = f;
    #1;
    check({tag, "_gnt"},  use4 ? 32'(gnt4) : 32'(gnt1), 32'(eg));
    check({tag, "_wr"},   use4 ? 32'(wr4)  : 32'(wr1),  32'(|eg));
    check({tag, "_data"}, use4 ? wd4 : wd1, exp_data(eg));
    @(posedge clk); #1;
    check({tag, "_burst"}, use4 ? 32'(bur4) : 32'(bur1), 32'(eb));
    check({tag, "_owner"}, use4 ? 32'(own4) : 32'(own1), 32'(eo));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; full = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [NR-1:0] s2_g [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                              4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
  logic          s2_b [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0]    s2_o [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};

  initial begin
    for (int k = 0; k < NR; k++) data[k*DW +: DW] = dval(k);

    // Reset with all requests high: no grant may leak out.
    rst_n = 1'b0; req = 4'b1111; full = 1'b0;
    #1;
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_wr1",  32'(wr1),  32'd0);
    check("rst_gnt4", 32'(gnt4), 32'd0);
    check("rst_wr4",  32'(wr4),  32'd0);
    @(posedge clk); #1;
    check("rst_owner4", 32'(own4), 32'd0);
    check("rst_burst4", 32'(bur4), 32'd0);
    check("rst_data4",  wd4, 32'd0);

    // MAX_BURST=1: pure per-word round robin starting at requester 0.
    for (int i = 0; i < 6; i++)
      step(1'b0, $sformatf("rr%0d", i), 4'b1111, 1'b0, 4'(1 << (i % 4)), 1'b0, 2'(i % 4));

    // MAX_BURST=4 with requesters 0 and 2: bursts of four alternate.
    do_reset();
    for (int i = 0; i < 9; i++)
      step(1'b1, $sformatf("bu%0d", i), 4'b0101, 1'b0, s2_g[i], s2_b[i], s2_o[i]);

    // Full stalls owner 1 mid-burst; it resumes for exactly two more words.
    do_reset();
    step(1'b1, "fs_a", 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1);
    step(1'b1, "fs_b", 4'b0011, 1'b0, 4'b0010, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++)
      step(1'b1, $sformatf("fs_full%0d", i), 4'b0011, 1'b1, 4'b0000, 1'b1, 2'd1);
    step(1'b1, "fs_c", 4'b0011, 1'b0, 4'b0010, 1'b1, 2'd1);
    step(1'b1, "fs_d", 4'b0011, 1'b0, 4'b0010, 1'b0, 2'd1);
    step(1'b1, "fs_e", 4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0);

    // Owner 3 withdraws after one write: one bubble, then requester 0.
    do_reset();
    step(1'b1, "wd_a", 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3);
    step(1'b1, "wd_bubble", 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd3);
    step(1'b1, "wd_c", 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0);

    // Reset mid-burst of owner 2, then requester 1 wins first.
    do_reset();
    step(1'b1, "mr_a", 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2);
    rst_n = 1'b0; req = 4'b0100; full = 1'b0;
    #1;
    check("mr_rst_gnt", 32'(gnt4), 32'd0);
    check("mr_rst_wr",  32'(wr4),  32'd0);
    @(posedge clk); #1;
    check("mr_rst_burst", 32'(bur4), 32'd0);
    check("mr_rst_owner", 32'(own4), 32'd0);
    step(1'b1, "mr_b", 4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1);
    step(1'b1, "mr_full", 4'b0110, 1'b1, 4'b0000, 1'b1, 2'd1);

`ifdef SYNC_FIFO_ARB_STATS_EN
    // 10 writes then 5 full-stalled request cycles.
    do_reset();
    check("st_rst_wr",    wcnt4,  32'd0);
    check("st_rst_stall", stall4, 32'd0);
    rst_n = 1'b1; req = 4'b1111; full = 1'b0;
    repeat (10) @(posedge clk);
    #1; full = 1'b1;
    repeat (5) @(posedge clk);
    #1; req = '0; full = 1'b0;
    @(posedge clk); #1;
    check("st_wr",    wcnt4,  32'd10);
    check("st_stall", stall4, 32'd5);
    check("st_wr1",   wcnt1,  32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
